// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate-field extender feeding a 2-entry output stage
// (main register + skid register) with a registered in_ready.
// Optional build macro IMM_EXT_BRANCH_EN enables branch mode (op 3) and
// out_ovf; without it, op 3 zero-extends and out_ovf stays 0.
module imm_ext_pipe #(
   parameter int IMM_W = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IMM_W-1:0] in_imm,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_ovf
);

   localparam int PAD_W = OUT_W - IMM_W;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [TAG_W-1:0] tag;
      logic             ovf;
   } beat_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t state_q, state_d;
   beat_t  main_q, main_d, skid_q, skid_d, new_b;
   logic   rdy_q;
   logic   acc, drn;

   logic [OUT_W-1:0] zext, sext, upper;

   assign zext  = {{PAD_W{1'b0}}, in_imm};
   assign sext  = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
   // IMM_W + PAD_W == OUT_W, so the immediate lands exactly in the top bits
   assign upper = {in_imm, {PAD_W{1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
   logic [OUT_W-1:0] branch;
   logic             br_ovf;

   assign branch = {sext[OUT_W-3:0], 2'b00};
   // the two bits shifted out must both equal the new sign bit
   assign br_ovf = (sext[OUT_W-1] ^ sext[OUT_W-3]) | (sext[OUT_W-2] ^ sext[OUT_W-3]);
`endif

   // extend the incoming immediate according to the requested mode
   always_comb begin
      new_b      = '0;
      new_b.tag  = in_tag;
      new_b.data = zext;
      new_b.ovf  = 1'b0;
      case (in_op)
         2'd1: new_b.data = sext;
         2'd2: new_b.data = upper;
`ifdef IMM_EXT_BRANCH_EN
         2'd3: begin
            new_b.data = branch;
            new_b.ovf  = br_ovf;
         end
`endif
         default: new_b.data = zext;
      endcase
   end

   assign acc = in_valid & rdy_q;
   assign drn = (state_q != EMPTY) & out_ready;

   // next-state and storage updates; main is cleared whenever it empties so
   // the outputs read 0 while idle
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (acc) begin
               main_d  = new_b;
               state_d = ONE;
            end
         end
         ONE: begin
            if (acc && drn) begin
               main_d = new_b;
            end else if (drn) begin
               main_d  = '0;
               state_d = EMPTY;
            end else if (acc) begin
               skid_d  = new_b;
               state_d = FULL;
            end
         end
         FULL: begin
            if (drn) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = ONE;
            end
         end
         default: begin
            main_d  = '0;
            skid_d  = '0;
            state_d = EMPTY;
         end
      endcase
   end

   // state, storage and registered ready; ready only depends on next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= (state_d != FULL);
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q.data;
   assign out_tag   = main_q.tag;
   assign out_ovf   = main_q.ovf;

endmodule
